idex_stage: RTL and testbench

Parametrised ID/EX pipeline stage for the in-order core. It sits between decode and the ALU.
- Resolves operand forwarding from the MEM and WB stages at capture time.
- Performs the a/b operand selection.
- Holds one instruction in an output register, backed by a one-entry skid slot, behind a valid/ready handshake.
- Supports stall (out_ready low) and synchronous flush (branch mispredict/trap), which the previous fixed register lacked.

---
 rtl/idex_pkg.sv | 28 ++
 rtl/idex_fwd_mux.sv | 33 +++
 rtl/idex_stage.sv | 178 +++++++++++++++++
 tb/tb_idex_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/idex_pkg.sv
// Shared types and constants for the ID/EX pipeline stage.
// Operand-select encodings and the fixed b-operand constants live here.
package idex_pkg;

    typedef enum logic [1:0] {
        A_RS1   = 2'd0,
        A_PC    = 2'd1,
        A_ZERO  = 2'd2,
        A_ZERO3 = 2'd3
    } a_sel_e;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_IMM  = 2'd1,
        B_FOUR = 2'd2,
        B_LUI  = 2'd3
    } b_sel_e;

    localparam int B_CONST_FOUR = 4;
    localparam int LUI_SHIFT    = 12;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } idex_state_e;

endpackage

// File: rtl/idex_fwd_mux.sv
// Priority forwarding for one source operand: MEM beats WB, index 0 is never forwarded.
module idex_fwd_mux #(
    parameter int WordSize    = 32,
    parameter int RegAddrBits = 5,
    parameter bit FwdEnable   = 1'b1
) (
    input  logic [RegAddrBits-1:0] rsn,
    input  logic [WordSize-1:0]    rf_data,
    input  logic                   mem_en,
    input  logic [RegAddrBits-1:0] mem_rdn,
    input  logic [WordSize-1:0]    mem_data,
    input  logic                   wb_en,
    input  logic [RegAddrBits-1:0] wb_rdn,
    input  logic [WordSize-1:0]    wb_data,
    output logic [WordSize-1:0]    data
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = FwdEnable && mem_en && (mem_rdn == rsn) && (rsn != '0);
    assign wb_hit  = FwdEnable && wb_en  && (wb_rdn  == rsn) && (rsn != '0);

    always_comb begin
        data = rf_data;
        if (mem_hit) begin
            data = mem_data;
        end else if (wb_hit) begin
            data = wb_data;
        end
    end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline stage: forwarding, operand select, output register plus one-entry skid
// slot behind a valid/ready handshake, with synchronous flush.
module idex_stage
    import idex_pkg::*;
#(
    parameter int WordSize    = 32,
    parameter int RegAddrBits = 5,
    parameter bit FwdEnable   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             a_sel,
    input  logic [1:0]             b_sel,
    input  logic [WordSize-1:0]    pc_in,
    input  logic [WordSize-1:0]    imm,
    input  logic [WordSize-1:0]    rs1d,
    input  logic [WordSize-1:0]    rs2d_in,
    input  logic [WordSize-1:0]    branch_addr_in,
    input  logic [RegAddrBits-1:0] rs1n,
    input  logic [RegAddrBits-1:0] rs2n,
    input  logic [RegAddrBits-1:0] rdn_in,
    input  logic                   branch_taken_in,
    input  logic                   mem_fwd_en,
    input  logic                   wb_fwd_en,
    input  logic [RegAddrBits-1:0] mem_fwd_rdn,
    input  logic [RegAddrBits-1:0] wb_fwd_rdn,
    input  logic [WordSize-1:0]    mem_fwd_data,
    input  logic [WordSize-1:0]    wb_fwd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WordSize-1:0]    pc,
    output logic [WordSize-1:0]    branch_addr,
    output logic [WordSize-1:0]    a,
    output logic [WordSize-1:0]    b,
    output logic [WordSize-1:0]    rs2d,
    output logic [RegAddrBits-1:0] rdn,
    output logic                   branch_taken
);

    typedef struct packed {
        logic [WordSize-1:0]    pc;
        logic [WordSize-1:0]    branch_addr;
        logic [WordSize-1:0]    a;
        logic [WordSize-1:0]    b;
        logic [WordSize-1:0]    rs2d;
        logic [RegAddrBits-1:0] rdn;
        logic                   branch_taken;
    } idex_payload_t;

    idex_state_e   state;
    idex_state_e   next_state;
    idex_payload_t captured;
    idex_payload_t out_q;
    idex_payload_t skid_q;
    logic [WordSize-1:0] fwd_rs1;
    logic [WordSize-1:0] fwd_rs2;
    logic xfer_in;
    logic xfer_out;
    logic load_out;
    logic load_skid;
    logic move_skid;

    idex_fwd_mux #(
        .WordSize(WordSize), .RegAddrBits(RegAddrBits), .FwdEnable(FwdEnable)
    ) u_fwd_rs1 (
        .rsn(rs1n), .rf_data(rs1d),
        .mem_en(mem_fwd_en), .mem_rdn(mem_fwd_rdn), .mem_data(mem_fwd_data),
        .wb_en(wb_fwd_en), .wb_rdn(wb_fwd_rdn), .wb_data(wb_fwd_data),
        .data(fwd_rs1)
    );

    idex_fwd_mux #(
        .WordSize(WordSize), .RegAddrBits(RegAddrBits), .FwdEnable(FwdEnable)
    ) u_fwd_rs2 (
        .rsn(rs2n), .rf_data(rs2d_in),
        .mem_en(mem_fwd_en), .mem_rdn(mem_fwd_rdn), .mem_data(mem_fwd_data),
        .wb_en(wb_fwd_en), .wb_rdn(wb_fwd_rdn), .wb_data(wb_fwd_data),
        .data(fwd_rs2)
    );

    always_comb begin
        captured              = '0;
        captured.pc           = pc_in;
        captured.branch_addr  = branch_addr_in;
        captured.rs2d         = fwd_rs2;
        captured.rdn          = rdn_in;
        captured.branch_taken = branch_taken_in;
        case (a_sel_e'(a_sel))
            A_RS1:   captured.a = fwd_rs1;
            A_PC:    captured.a = pc_in;
            default: captured.a = '0;
        endcase
        case (b_sel_e'(b_sel))
            B_RS2:   captured.b = fwd_rs2;
            B_IMM:   captured.b = imm;
            B_FOUR:  captured.b = WordSize'(B_CONST_FOUR);
            default: captured.b = imm << LUI_SHIFT;
        endcase
    end

    // in_ready depends only on registered state, so out_ready never reaches it combinationally.
    assign in_ready  = (state != ST_SKID);
    assign out_valid = (state != ST_EMPTY);
    assign xfer_in   = in_valid && in_ready;
    assign xfer_out  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load_out   = 1'b0;
        load_skid  = 1'b0;
        move_skid  = 1'b0;
        if (flush) begin
            next_state = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        next_state = ST_FULL;
                        load_out   = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (xfer_in && xfer_out) begin
                        load_out = 1'b1;
                    end else if (xfer_in) begin
                        next_state = ST_SKID;
                        load_skid  = 1'b1;
                    end else if (xfer_out) begin
                        next_state = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (xfer_out) begin
                        next_state = ST_FULL;
                        move_skid  = 1'b1;
                    end
                end
                default: next_state = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out) begin
                out_q <= captured;
            end else if (move_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= captured;
            end
        end
    end

    assign pc           = out_q.pc;
    assign branch_addr  = out_q.branch_addr;
    assign a            = out_q.a;
    assign b            = out_q.b;
    assign rs2d         = out_q.rs2d;
    assign rdn          = out_q.rdn;
    assign branch_taken = out_q.branch_taken;

endmodule

// File: tb/tb_idex_stage.sv
// Directed self-checking bench for idex_stage: forwarding, operand select, skid, flush, reset.
module tb_idex_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic [31:0] pc_in, imm, rs1d, rs2d_in, branch_addr_in;
    logic [4:0]  rs1n, rs2n, rdn_in;
    logic        branch_taken_in;
    logic        mem_fwd_en, wb_fwd_en;
    logic [4:0]  mem_fwd_rdn, wb_fwd_rdn;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc, branch_addr, a, b, rs2d;
    logic [4:0]  rdn;
    logic        branch_taken;

    int n_checks = 0;
    int n_fails  = 0;

    idex_stage #(.WordSize(32), .RegAddrBits(5), .FwdEnable(1'b1)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_sel(a_sel), .b_sel(b_sel),
        .pc_in(pc_in), .imm(imm), .rs1d(rs1d), .rs2d_in(rs2d_in),
        .branch_addr_in(branch_addr_in),
        .rs1n(rs1n), .rs2n(rs2n), .rdn_in(rdn_in),
        .branch_taken_in(branch_taken_in),
        .mem_fwd_en(mem_fwd_en), .wb_fwd_en(wb_fwd_en),
        .mem_fwd_rdn(mem_fwd_rdn), .wb_fwd_rdn(wb_fwd_rdn),
        .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc(pc), .branch_addr(branch_addr), .a(a), .b(b), .rs2d(rs2d),
        .rdn(rdn), .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_sel = 2'd0; b_sel = 2'd0;
        pc_in = '0; imm = '0; rs1d = '0; rs2d_in = '0; branch_addr_in = '0;
        rs1n = '0; rs2n = '0; rdn_in = '0; branch_taken_in = 1'b0;
        mem_fwd_en = 1'b0; wb_fwd_en = 1'b0; mem_fwd_rdn = '0; wb_fwd_rdn = '0;
        mem_fwd_data = '0; wb_fwd_data = '0;

        tick(); tick();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_a", a, 32'd0);
        check("reset_pc", pc, 32'd0);
        rstn = 1'b1;
        tick();

        // First instruction: a = pc, b = constant 4
        in_valid = 1'b1; out_ready = 1'b1; a_sel = 2'd1; b_sel = 2'd2; pc_in = 32'h100;
        tick();
        check("first_out_valid", 32'(out_valid), 32'd1);
        check("first_a_pc", a, 32'h100);
        check("first_b_four", b, 32'd4);
        check("first_pc", pc, 32'h100);
        check("first_in_ready", 32'(in_ready), 32'd1);

        // MEM beats WB on the same index
        a_sel = 2'd0; b_sel = 2'd1; imm = 32'h22; rs1n = 5'd5; rs1d = 32'h11;
        mem_fwd_en = 1'b1; mem_fwd_rdn = 5'd5; mem_fwd_data = 32'hAA;
        wb_fwd_en = 1'b1; wb_fwd_rdn = 5'd5; wb_fwd_data = 32'hBB;
        tick();
        check("fwd_mem_priority", a, 32'hAA);
        check("fwd_b_imm", b, 32'h22);

        // Index 0 never forwarded even when MEM/WB target x0
        rs1n = 5'd0; mem_fwd_rdn = 5'd0; wb_fwd_rdn = 5'd0;
        tick();
        check("fwd_x0_blocked", a, 32'h11);

        // WB-only hit
        rs1n = 5'd3; mem_fwd_rdn = 5'd4; wb_fwd_rdn = 5'd3;
        tick();
        check("fwd_wb_only", a, 32'hBB);

        // b = imm << 12, truncated
        b_sel = 2'd3; imm = 32'h000FFFFF;
        tick();
        check("b_lui_shift", b, 32'hFFFFF000);

        // rs2 forwarded from WB into both b and rs2d payload
        b_sel = 2'd0; rs2n = 5'd7; rs2d_in = 32'h77; mem_fwd_en = 1'b0;
        wb_fwd_rdn = 5'd7; rdn_in = 5'd9; branch_taken_in = 1'b1; branch_addr_in = 32'h300;
        tick();
        check("b_wb_fwd", b, 32'hBB);
        check("rs2d_wb_fwd", rs2d, 32'hBB);
        check("rdn_payload", 32'(rdn), 32'd9);
        check("branch_taken_payload", 32'(branch_taken), 32'd1);
        check("branch_addr_payload", branch_addr, 32'h300);

        in_valid = 1'b0; wb_fwd_en = 1'b0; branch_taken_in = 1'b0;
        tick();
        check("drain_empty", 32'(out_valid), 32'd0);

        // Stall: I1 then I2 fill output and skid
        out_ready = 1'b0; in_valid = 1'b1; a_sel = 2'd1; b_sel = 2'd1;
        pc_in = 32'h1000; imm = 32'd1;
        tick();
        check("stall_i1_valid", 32'(out_valid), 32'd1);
        check("stall_i1_in_ready", 32'(in_ready), 32'd1);
        pc_in = 32'h2000; imm = 32'd2;
        tick();
        check("skid_in_ready_low", 32'(in_ready), 32'd0);
        check("skid_hold_a", a, 32'h1000);
        pc_in = 32'h3000; imm = 32'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("skid_hold_valid", 32'(out_valid), 32'd1);
            check("skid_hold_a", a, 32'h1000);
            check("skid_hold_b", b, 32'd1);
            check("skid_hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("skid_release_i2_a", a, 32'h2000);
        check("skid_release_i2_b", b, 32'd2);
        check("skid_release_valid", 32'(out_valid), 32'd1);
        check("skid_release_ready", 32'(in_ready), 32'd1);
        tick();
        check("skid_drained", 32'(out_valid), 32'd0);

        // Flush while in SKID with a new input presented
        out_ready = 1'b0; in_valid = 1'b1; pc_in = 32'h1000;
        tick();
        pc_in = 32'h2000;
        tick();
        check("flush_pre_skid", 32'(in_ready), 32'd0);
        flush = 1'b1; pc_in = 32'h4000;
        tick();
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("flush_nothing_appears", 32'(out_valid), 32'd0);
        end

        // Asynchronous reset mid-SKID
        out_ready = 1'b0; in_valid = 1'b1; pc_in = 32'h1000; b_sel = 2'd2;
        tick();
        pc_in = 32'h2000;
        tick();
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("async_reset_valid", 32'(out_valid), 32'd0);
        check("async_reset_ready", 32'(in_ready), 32'd1);
        check("async_reset_a", a, 32'd0);
        check("async_reset_b", b, 32'd0);
        check("async_reset_pc", pc, 32'd0);
        #1 rstn = 1'b1;
        tick();

        // Back-to-back stream, one per cycle
        out_ready = 1'b1; in_valid = 1'b1; a_sel = 2'd1; b_sel = 2'd1;
        for (int i = 0; i < 6; i++) begin
            pc_in = 32'h500 + 32'(i);
            imm = 32'(i);
            tick();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_a", a, 32'h500 + 32'(i));
            check("stream_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_empty", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
